// File: rtl/m1_portb_arbiter_if.sv
// rtl/m1_portb_arbiter_if.sv - requester and SRAM port B bundle for m1_portb_arbiter
interface m1_portb_arbiter_if #(
  parameter int g_addr_width = 6,
  parameter int g_data_width = 16
);
  logic                    req0;
  logic [g_addr_width-1:0] adr0;
  logic                    ack0;
  logic [g_data_width-1:0] dat0;
  logic                    req1;
  logic [g_addr_width-1:0] adr1;
  logic                    ack1;
  logic [g_data_width-1:0] dat1;
  logic [g_addr_width-1:0] ram_adr;
  logic                    ram_rd;
  logic [g_data_width-1:0] ram_dat;
  logic                    busy;

  modport slave (
    input  req0, adr0, req1, adr1, ram_dat,
    output ack0, dat0, ack1, dat1, ram_adr, ram_rd, busy
  );

  modport master (
    output req0, adr0, req1, adr1, ram_dat,
    input  ack0, dat0, ack1, dat1, ram_adr, ram_rd, busy
  );
endinterface

// File: rtl/m1_portb_arbiter.sv
// rtl/m1_portb_arbiter.sv - two-requester arbiter for the read-only B port of the m1 SRAM
// One access in flight: IDLE -> ISSUE (strobe) -> WAIT (capture) -> ACK (pulse).
module m1_portb_arbiter #(
  parameter int g_addr_width = 6,
  parameter int g_data_width = 16,
  parameter int g_fixed_prio = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  m1_portb_arbiter_if.slave      io_bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_ACK   = 2'd3;

  logic [1:0]              r_state;
  logic                    r_winner;
  logic                    r_last_grant;
  logic [g_addr_width-1:0] r_ram_adr;
  logic                    r_ram_rd;
  logic                    r_ack0;
  logic                    r_ack1;
  logic [g_data_width-1:0] r_dat0;
  logic [g_data_width-1:0] r_dat1;
  logic                    r_busy;

  logic                    w_any_req;
  logic                    w_win;

  assign w_any_req = io_bus.req0 | io_bus.req1;

  // On a tie the requester not served last wins, unless priority is fixed.
  always_comb begin
    w_win = 1'b0;
    if (io_bus.req0 && io_bus.req1) begin
      if (g_fixed_prio != 0) begin
        w_win = 1'b0;
      end else begin
        w_win = ~r_last_grant;
      end
    end else if (io_bus.req1) begin
      w_win = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_winner     <= 1'b0;
      r_last_grant <= 1'b1;
      r_ram_adr    <= '0;
      r_ram_rd     <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_dat0       <= '0;
      r_dat1       <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_ram_rd <= 1'b0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_winner     <= w_win;
            r_last_grant <= w_win;
            r_ram_adr    <= w_win ? io_bus.adr1 : io_bus.adr0;
            r_ram_rd     <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // RAM output is valid this cycle; ack follows the capture.
          if (r_winner) begin
            r_dat1 <= io_bus.ram_dat;
            r_ack1 <= 1'b1;
          end else begin
            r_dat0 <= io_bus.ram_dat;
            r_ack0 <= 1'b1;
          end
          r_state <= ST_ACK;
        end
        ST_ACK: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_bus.ack0    = r_ack0;
  assign io_bus.dat0    = r_dat0;
  assign io_bus.ack1    = r_ack1;
  assign io_bus.dat1    = r_dat1;
  assign io_bus.ram_adr = r_ram_adr;
  assign io_bus.ram_rd  = r_ram_rd;
  assign io_bus.busy    = r_busy;

endmodule

// File: tb/tb_m1_portb_arbiter.sv
// tb/tb_m1_portb_arbiter.sv - directed bench for m1_portb_arbiter (round-robin and fixed priority)
module tb_m1_portb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  m1_portb_arbiter_if #(.g_addr_width(6), .g_data_width(16)) b_rr ();
  m1_portb_arbiter_if #(.g_addr_width(6), .g_data_width(16)) b_fx ();

  m1_portb_arbiter #(.g_addr_width(6), .g_data_width(16), .g_fixed_prio(0)) u_rr (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (b_rr)
  );

  m1_portb_arbiter #(.g_addr_width(6), .g_data_width(16), .g_fixed_prio(1)) u_fx (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (b_fx)
  );

  logic [15:0] mem [64];

  // 1-cycle registered read, like cheby_dpssram port B
  always @(posedge clk) begin
    if (b_rr.ram_rd) b_rr.ram_dat <= mem[b_rr.ram_adr];
    if (b_fx.ram_rd) b_fx.ram_dat <= mem[b_fx.ram_adr];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    b_rr.req0 = 1'b0; b_rr.req1 = 1'b0; b_rr.adr0 = '0; b_rr.adr1 = '0;
    b_fx.req0 = 1'b0; b_fx.req1 = 1'b0; b_fx.adr0 = '0; b_fx.adr1 = '0;
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  task automatic set_req(input bit fx, input bit idx, input bit val);
    if (fx) begin
      if (idx) b_fx.req1 = val; else b_fx.req0 = val;
    end else begin
      if (idx) b_rr.req1 = val; else b_rr.req0 = val;
    end
  endtask

  // Both requesters keep asking; each acked one drops on the ack edge and re-raises in IDLE.
  task automatic run_contention(input bit fx);
    bit got_ack;
    bit who;
    bit exp_who;
    logic [15:0] d;
    if (fx) begin
      b_fx.adr0 = 6'h02; b_fx.adr1 = 6'h03;
    end else begin
      b_rr.adr0 = 6'h02; b_rr.adr1 = 6'h03;
    end
    set_req(fx, 1'b0, 1'b1);
    set_req(fx, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      got_ack = 1'b0;
      who = 1'b0;
      for (int t = 0; t < 8 && !got_ack; t++) begin
        cyc();
        if (fx ? b_fx.ack0 : b_rr.ack0) begin got_ack = 1'b1; who = 1'b0; end
        else if (fx ? b_fx.ack1 : b_rr.ack1) begin got_ack = 1'b1; who = 1'b1; end
      end
      chk(fx ? "fx_ack_seen" : "rr_ack_seen", 16'(got_ack), 16'd1);
      exp_who = fx ? 1'b0 : k[0];
      chk(fx ? "fx_grant" : "rr_grant", 16'(who), 16'(exp_who));
      if (fx) d = who ? b_fx.dat1 : b_fx.dat0;
      else    d = who ? b_rr.dat1 : b_rr.dat0;
      chk(fx ? "fx_data" : "rr_data", d, who ? 16'h0303 : 16'h0202);
      set_req(fx, who, 1'b0);
      cyc();
      set_req(fx, who, 1'b1);
    end
    set_req(fx, 1'b0, 1'b0);
    set_req(fx, 1'b1, 1'b0);
    repeat (4) cyc();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {2'b00, i[5:0], 2'b00, i[5:0]};
    mem[1] = 16'h1111;
    mem[5] = 16'hBEEF;

    do_reset();
    chk("rst_ack0", 16'(b_rr.ack0), 16'd0);
    chk("rst_ack1", 16'(b_rr.ack1), 16'd0);
    chk("rst_ram_rd", 16'(b_rr.ram_rd), 16'd0);
    chk("rst_ram_adr", 16'(b_rr.ram_adr), 16'd0);
    chk("rst_dat0", b_rr.dat0, 16'h0000);
    chk("rst_dat1", b_rr.dat1, 16'h0000);
    chk("rst_busy", 16'(b_rr.busy), 16'd0);

    // single read of requester 0
    b_rr.req0 = 1'b1; b_rr.adr0 = 6'h05;
    cyc();
    chk("t1_ram_rd", 16'(b_rr.ram_rd), 16'd1);
    chk("t1_ram_adr", 16'(b_rr.ram_adr), 16'h05);
    chk("t1_busy", 16'(b_rr.busy), 16'd1);
    chk("t1_ack0", 16'(b_rr.ack0), 16'd0);
    cyc();
    chk("t2_ram_rd", 16'(b_rr.ram_rd), 16'd0);
    chk("t2_busy", 16'(b_rr.busy), 16'd1);
    chk("t2_ack0", 16'(b_rr.ack0), 16'd0);
    cyc();
    chk("t3_ack0", 16'(b_rr.ack0), 16'd1);
    chk("t3_dat0", b_rr.dat0, 16'hBEEF);
    chk("t3_ack1", 16'(b_rr.ack1), 16'd0);
    chk("t3_busy", 16'(b_rr.busy), 16'd1);
    b_rr.req0 = 1'b0;
    cyc();
    chk("t4_ack0", 16'(b_rr.ack0), 16'd0);
    chk("t4_busy", 16'(b_rr.busy), 16'd0);
    chk("t4_adr_kept", 16'(b_rr.ram_adr), 16'h05);

    // reset during WAIT aborts the read
    b_rr.req0 = 1'b1; b_rr.adr0 = 6'h02;
    cyc();
    cyc();
    rst = 1'b1;
    b_rr.req0 = 1'b0;
    #1;
    chk("abort_ack0", 16'(b_rr.ack0), 16'd0);
    chk("abort_dat0", b_rr.dat0, 16'h0000);
    chk("abort_busy", 16'(b_rr.busy), 16'd0);
    chk("abort_ram_rd", 16'(b_rr.ram_rd), 16'd0);
    cyc();
    rst = 1'b0;
    b_rr.req0 = 1'b1;
    repeat (3) cyc();
    chk("abort_retry_ack0", 16'(b_rr.ack0), 16'd1);
    chk("abort_retry_dat0", b_rr.dat0, 16'h0202);
    b_rr.req0 = 1'b0;
    cyc();

    // simultaneous requests from reset
    do_reset();
    b_rr.req0 = 1'b1; b_rr.adr0 = 6'h01;
    b_rr.req1 = 1'b1; b_rr.adr1 = 6'h3F;
    repeat (3) cyc();
    chk("tie_ack0", 16'(b_rr.ack0), 16'd1);
    chk("tie_dat0", b_rr.dat0, 16'h1111);
    chk("tie_ack1_first", 16'(b_rr.ack1), 16'd0);
    b_rr.req0 = 1'b0;
    repeat (4) cyc();
    chk("tie_ack1", 16'(b_rr.ack1), 16'd1);
    chk("tie_dat1", b_rr.dat1, 16'h3F3F);
    chk("tie_dat0_kept", b_rr.dat0, 16'h1111);
    b_rr.req1 = 1'b0;
    cyc();

    // req1 arrives during ISSUE of a requester 0 access
    b_rr.req0 = 1'b1; b_rr.adr0 = 6'h0A;
    cyc();
    b_rr.req1 = 1'b1; b_rr.adr1 = 6'h0C;
    cyc();
    cyc();
    chk("late_ack0", 16'(b_rr.ack0), 16'd1);
    chk("late_dat0", b_rr.dat0, 16'h0A0A);
    b_rr.req0 = 1'b0;
    cyc();
    chk("late_idle_rd", 16'(b_rr.ram_rd), 16'd0);
    cyc();
    chk("late_rd1", 16'(b_rr.ram_rd), 16'd1);
    chk("late_adr1", 16'(b_rr.ram_adr), 16'h0C);
    repeat (2) cyc();
    chk("late_ack1", 16'(b_rr.ack1), 16'd1);
    chk("late_dat1", b_rr.dat1, 16'h0C0C);
    b_rr.req1 = 1'b0;
    cyc();

    // req0 dropped during ISSUE still gets its ack
    b_rr.req0 = 1'b1; b_rr.adr0 = 6'h07;
    cyc();
    b_rr.req0 = 1'b0;
    b_rr.req1 = 1'b1; b_rr.adr1 = 6'h09;
    cyc();
    cyc();
    chk("drop_ack0", 16'(b_rr.ack0), 16'd1);
    chk("drop_dat0", b_rr.dat0, 16'h0707);
    cyc();
    cyc();
    chk("drop_rd1", 16'(b_rr.ram_rd), 16'd1);
    chk("drop_adr1", 16'(b_rr.ram_adr), 16'h09);
    repeat (2) cyc();
    chk("drop_ack1", 16'(b_rr.ack1), 16'd1);
    chk("drop_dat1", b_rr.dat1, 16'h0909);
    b_rr.req1 = 1'b0;
    cyc();

    do_reset();
    run_contention(1'b0);
    do_reset();
    run_contention(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/m1_portb_arbiter.md
Name: m1_portb_arbiter

Overview:
- Round-robin arbiter sharing the read-only B port of the m1 dual-port SRAM (64 x 16, `cheby_dpssram`, 1-cycle registered read) between two internal requesters.
- Port A stays owned by the VME register bank.
- Block sits between port B (`m1_adr_i` / `m1_r1_rd_i` / `m1_r1_dat_o`) and two user-logic readers, e.g. a sequencer and a monitor.
- Serialises requests, drives the RAM strobe and address, and returns the data word with a one-cycle acknowledge pulse.

Parameters:
- g_addr_width, 6: RAM word-address width.
- g_data_width, 16: RAM data width.
- g_fixed_prio, 0: 0 = round-robin; 1 = requester 0 always wins ties.

Ports:
- Clk  in  1  system clock, all logic on rising edge
- Rst  in  1  asynchronous reset, active high
- req0_i  in  1  requester 0 read request, level, held until ack0_o
- adr0_i  in  g_addr_width  requester 0 word address, stable while req0_i high
- ack0_o  out  1  one-cycle pulse, dat0_o valid
- dat0_o  out  g_data_width  requester 0 read data, held until next ack0_o
- req1_i  in  1  requester 1 read request
- adr1_i  in  g_addr_width  requester 1 word address
- ack1_o  out  1  requester 1 acknowledge pulse
- dat1_o  out  g_data_width  requester 1 read data
- ram_adr_o  out  g_addr_width  to SRAM port B address
- ram_rd_o  out  1  to SRAM port B read strobe
- ram_dat_i  in  g_data_width  from SRAM port B data, valid the cycle after ram_rd_o
- busy_o  out  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, Rst=1):
  - state=IDLE.
  - ack0_o=ack1_o=0, ram_rd_o=0.
  - ram_adr_o=0, dat0_o=dat1_o=0, busy_o=0.
  - last_grant=1, so requester 0 wins the first tie.
- All outputs are registered; no combinational input-to-output path.
- IDLE:
  - If any req is high, select a winner, register winner index, load ram_adr_o with the winner's address, go to ISSUE.
  - Otherwise stay in IDLE.
- Arbitration:
  - Only one request high: that requester wins.
  - Both high, g_fixed_prio=0: the requester other than last_grant wins; last_grant updates on every grant.
  - Both high, g_fixed_prio=1: requester 0 wins.
- ISSUE: ram_rd_o=1 for exactly this cycle, ram_adr_o stable, go to WAIT.
- WAIT:
  - ram_rd_o=0; ram_dat_i is valid.
  - At the end of the cycle, capture ram_dat_i into the winner's dat register; the other dat register is unchanged.
  - Go to ACK.
- ACK: winner's ack is high for this single cycle, then go to IDLE.
- Requesters sample ack at the closing edge and drop req on that same edge, so IDLE never re-grants a served request.
- Latency and throughput:
  - req high in cycle T0 (state IDLE) gives ram_rd_o in T1, data captured at the end of T2, ack in T3.
  - 4 cycles per access; one access in flight at a time.
- Requests arriving outside IDLE wait; they are never lost.
- ram_adr_o keeps the last address after completion; it never changes outside the IDLE-to-ISSUE edge.
- A req dropped before its ack: the transaction still completes and the ack still pulses; the requester ignores it.
- Address changed while req high: undefined. Only the value sampled in IDLE is used.
- Rst asserted mid-transaction: immediate return to IDLE with reset values, no ack issued. The aborted read has no side effects, since port B is read-only.
- Width rules: addresses and data pass through unmodified; there is no wrap or arithmetic.

Test Plan:
- Reset, then req0_i=1, adr0_i=0x05, RAM[5]=0xBEEF -> ram_rd_o high with ram_adr_o=0x05 in T1; ack0_o pulses in T3 with dat0_o=0xBEEF; busy_o high for T1–T3; ack1_o stays 0.
- req0_i and req1_i both high from reset, adr0=0x01 (0x1111), adr1=0x3F (0x3F3F) -> requester 0 acks first with 0x1111; requester 1 acks 4 cycles later with 0x3F3F; dat0_o still 0x1111.
- Both requesters re-request continuously for 6 accesses, g_fixed_prio=0 -> grants alternate 0,1,0,1,0,1. With g_fixed_prio=1 -> requester 0 served every time while its req stays high.
- req1_i asserted during ISSUE of a requester 0 access -> requester 1 granted in the IDLE cycle after ack0_o; ram_rd_o for requester 1 is exactly 2 cycles after ack0_o.
- Rst pulsed during WAIT -> no ack, dat0_o=0, state IDLE, ram_rd_o=0. A new req0_i after release completes normally with 3-cycle latency.
- req0_i dropped during ISSUE -> ack0_o still pulses in ACK with the RAM data; the next grant goes to any pending req1_i.
